// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline registers
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards, branch
//   redirects and data-memory wait states, and drives per-register
//   enable/flush/bubble strobes so that no write-back is lost or duplicated.
//   It drives only control strobes and never touches datapath values.
//
// Parameters
//   MEM_TIMEOUT  max consecutive mem_ready-low cycles in MEM_WAIT before fault (>=1)
//   CNT_W        width of stall_cnt
//
// Optional feature macro
//   PIPE_STALL_CNT_EN  when defined, stall_cnt counts every post-reset cycle
//                      with pc_en=0 (wrapping). When undefined, stall_cnt is
//                      tied to zero and no counter flops exist.
//
// Ports
//   CLK                 in   clock, rising edge
//   Reset_in            in   asynchronous active-low reset
//   id_rs, id_rt        in   ID source register addresses
//   id_uses_rt          in   ID instruction reads rt
//   ex_memToReg         in   EX instruction is a load
//   ex_regShouldWrite   in   EX instruction writes the register file
//   ex_regWriteAddress  in   EX destination register
//   branch_taken        in   EX resolved a taken branch/jump
//   mem_req, mem_ready  in   MEM stage access request / completion
//   pc_en, ifid_en, idex_en, exmem_en   out  register load enables
//   ifid_flush, idex_flush              out  load NOP / bubble
//   memwb_bubble                        out  MEM-WB captures regShouldWrite=0
//   mem_fault                           out  sticky memory-timeout flag
//   stall_cnt                           out  stall-cycle counter
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             Reset_in,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memToReg,
   input  logic             ex_regShouldWrite,
   input  logic [4:0]       ex_regWriteAddress,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   state_t        state, stateNext;
   logic [TW-1:0] waitCnt, waitCntNext;
   logic          memFaultReg, memFaultNext;
   logic          loadUse;

   // A load in EX whose destination feeds the ID instruction; r0 never hazards.
   assign loadUse = ex_memToReg & ex_regShouldWrite & (ex_regWriteAddress != 5'd0)
                  & ((ex_regWriteAddress == id_rs)
                     | (id_uses_rt & (ex_regWriteAddress == id_rt)));

   // State, wait counter and sticky fault flag.
   always_ff @(posedge CLK or negedge Reset_in) begin
      if (!Reset_in) begin
         state       <= RUN;
         waitCnt     <= {TW{1'b0}};
         memFaultReg <= 1'b0;
      end else begin
         state       <= stateNext;
         waitCnt     <= waitCntNext;
         memFaultReg <= memFaultNext;
      end
   end

   // Next-state and strobe decode. All strobes are held low while reset is
   // asserted so the pipeline is frozen without needing a clock edge.
   always_comb begin
      stateNext    = state;
      waitCntNext  = waitCnt;
      memFaultNext = memFaultReg;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      if (!Reset_in) begin
         stateNext   = RUN;
         waitCntNext = {TW{1'b0}};
      end else begin
         case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  // Memory stall wins: EX is frozen, so a branch or hazard
                  // seen now is re-evaluated once the pipeline resumes.
                  memwb_bubble = 1'b1;
                  stateNext    = MEM_WAIT;
                  waitCntNext  = TW'(1);
               end else if (branch_taken) begin
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (loadUse) begin
                  // Hold PC and IF/ID for one cycle; ID/EX loads a bubble.
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  idex_flush = 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  // Release in the same cycle the MEM result is available.
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  idex_en     = 1'b1;
                  exmem_en    = 1'b1;
                  stateNext   = RUN;
                  waitCntNext = {TW{1'b0}};
               end else if (waitCnt == TIMEOUT_V) begin
                  memwb_bubble = 1'b1;
                  stateNext    = FAULT;
                  memFaultNext = 1'b1;
               end else begin
                  memwb_bubble = 1'b1;
                  waitCntNext  = waitCnt + TW'(1);
               end
            end
            FAULT: begin
               memwb_bubble = 1'b1;
            end
            default: begin
               memwb_bubble = 1'b1;
               stateNext    = RUN;
               waitCntNext  = {TW{1'b0}};
            end
         endcase
      end
   end

   assign mem_fault = memFaultReg;

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stallCntReg;

   // Counts cycles in which the PC is held; wraps naturally.
   always_ff @(posedge CLK or negedge Reset_in) begin
      if (!Reset_in) begin
         stallCntReg <= {CNT_W{1'b0}};
      end else if (!pc_en) begin
         stallCntReg <= stallCntReg + CNT_W'(1);
      end else begin
         stallCntReg <= stallCntReg;
      end
   end

   assign stall_cnt = stallCntReg;
`else
   assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (built with MEM_TIMEOUT=4).
//   Each step drives one cycle of sideband inputs and pushes the expected
//   strobe vector {pc_en,ifid_en,idex_en,exmem_en,ifid_flush,idex_flush,
//   memwb_bubble,mem_fault} onto a scoreboard queue; the sample on the
//   falling edge pops and compares it. A stall-cycle model tracks stall_cnt.
module tb_pipe_hazard_ctrl;

   localparam logic [7:0] E_RUN   = 8'b1111_0000;
   localparam logic [7:0] E_LU    = 8'b0011_0100;
   localparam logic [7:0] E_BR    = 8'b1111_1100;
   localparam logic [7:0] E_STALL = 8'b0000_0010;
   localparam logic [7:0] E_FAULT = 8'b0000_0011;
   localparam logic [7:0] E_RST   = 8'b0000_0000;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ur;
      logic       m2r;
      logic       rw;
      logic [4:0] wa;
      logic       br;
      logic       rq;
      logic       rd;
      logic [7:0] exp;
   } step_t;

   logic        CLK = 1'b0;
   logic        Reset_in;
   logic [4:0]  id_rs, id_rt, ex_regWriteAddress;
   logic        id_uses_rt, ex_memToReg, ex_regShouldWrite;
   logic        branch_taken, mem_req, mem_ready;
   logic        pc_en, ifid_en, idex_en, exmem_en;
   logic        ifid_flush, idex_flush, memwb_bubble, mem_fault;
   logic [31:0] stall_cnt;
   logic [7:0]  obs;

   int          nChecks = 0;
   int          nFail   = 0;
   int          stallModel = 0;
   logic [7:0]  expQ[$];

   assign obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_fault};

   always #5 CLK = ~CLK;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .CLK(CLK), .Reset_in(Reset_in),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memToReg(ex_memToReg), .ex_regShouldWrite(ex_regShouldWrite),
      .ex_regWriteAddress(ex_regWriteAddress), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
      .mem_fault(mem_fault), .stall_cnt(stall_cnt)
   );

   function automatic step_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                input logic m2r, input logic rw, input logic [4:0] wa,
                                input logic br, input logic rq, input logic rd, input logic [7:0] exp);
      step_t s;
      s = {rs, rt, ur, m2r, rw, wa, br, rq, rd, exp};
      return s;
   endfunction

   function automatic logic [31:0] expCnt();
`ifdef PIPE_STALL_CNT_EN
      return 32'(stallModel);
`else
      return 32'd0;
`endif
   endfunction

   // Drive one cycle of stimulus just after the rising edge and queue its expectation.
   task automatic apply(input step_t s);
      @(posedge CLK);
      #1;
      id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.ur;
      ex_memToReg = s.m2r; ex_regShouldWrite = s.rw; ex_regWriteAddress = s.wa;
      branch_taken = s.br; mem_req = s.rq; mem_ready = s.rd;
      expQ.push_back(s.exp);
   endtask

   task automatic test_reset();
      logic [7:0] e;
      step_t s;
      Reset_in = 1'b0;
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memToReg = 1'b0;
      ex_regShouldWrite = 1'b0; ex_regWriteAddress = 5'd0;
      branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      #3;
      expQ.push_back(E_RST);
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e) begin nFail++; $display("FAIL reset_outputs: got %b expected %b", obs, e); end
      nChecks++;
      if (stall_cnt !== 32'd0) begin nFail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
      @(negedge CLK);
      Reset_in = 1'b1;
      stallModel = 0;
      s = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN);
      apply(s);
      @(negedge CLK);
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e) begin nFail++; $display("FAIL reset_idle_run: got %b expected %b", obs, e); end
   endtask

   task automatic test_load_use();
      step_t s[$];
      logic [7:0] e;
      s.push_back(mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU));   // rs match
      s.push_back(mk(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, E_RUN));  // load moved on
      s.push_back(mk(5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, E_LU));   // rt match
      s.push_back(mk(5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN));
      s.push_back(mk(5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, E_RUN));  // load no write
      s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN));  // r0 never stalls
      s.push_back(mk(5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_RUN));  // rt not used
      s.push_back(mk(5'd8, 5'd5, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_RUN));  // ALU op, no load
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge CLK);
         e = expQ.pop_front();
         nChecks++;
         if (obs !== e) begin nFail++; $display("FAIL load_use step %0d: got %b expected %b", i, obs, e); end
         nChecks++;
         if (stall_cnt !== expCnt()) begin nFail++; $display("FAIL load_use_cnt step %0d: got %0d expected %0d", i, stall_cnt, expCnt()); end
         if (!e[7]) stallModel++;
      end
   endtask

   task automatic test_branch();
      step_t s[$];
      logic [7:0] e;
      s.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_BR));   // branch beats load-use
      s.push_back(mk(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, E_BR));
      s.push_back(mk(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN));  // ready access, no stall
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge CLK);
         e = expQ.pop_front();
         nChecks++;
         if (obs !== e) begin nFail++; $display("FAIL branch step %0d: got %b expected %b", i, obs, e); end
         nChecks++;
         if (stall_cnt !== expCnt()) begin nFail++; $display("FAIL branch_cnt step %0d: got %0d expected %0d", i, stall_cnt, expCnt()); end
         if (!e[7]) stallModel++;
      end
   endtask

   task automatic test_mem_wait();
      step_t s[$];
      logic [7:0] e;
      int base;
      base = stallModel;
      // Stall with a branch and load-use pending: both ignored.
      s.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_STALL));
      s.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_STALL));
      s.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_STALL));
      s.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, E_RUN));  // release
      s.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU));   // hazard re-evaluated
      s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge CLK);
         e = expQ.pop_front();
         nChecks++;
         if (obs !== e) begin nFail++; $display("FAIL mem_wait step %0d: got %b expected %b", i, obs, e); end
         nChecks++;
         if (stall_cnt !== expCnt()) begin nFail++; $display("FAIL mem_wait_cnt step %0d: got %0d expected %0d", i, stall_cnt, expCnt()); end
         if (i == 4) begin
            nChecks++;
            if (stallModel - base !== 3) begin nFail++; $display("FAIL mem_wait_len: got %0d stall cycles expected 3", stallModel - base); end
         end
         if (!e[7]) stallModel++;
      end
   endtask

   task automatic test_timeout();
      step_t s[$];
      step_t idle;
      logic [7:0] e;
      for (int k = 0; k < 5; k++)
         s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
      s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FAULT));
      s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_FAULT)); // held despite ready
      s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_FAULT));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge CLK);
         e = expQ.pop_front();
         nChecks++;
         if (obs !== e) begin nFail++; $display("FAIL timeout step %0d: got %b expected %b", i, obs, e); end
         nChecks++;
         if (stall_cnt !== expCnt()) begin nFail++; $display("FAIL timeout_cnt step %0d: got %0d expected %0d", i, stall_cnt, expCnt()); end
         if (!e[7]) stallModel++;
      end
      @(posedge CLK);
      #3;
      Reset_in = 1'b0;
      #1;
      stallModel = 0;
      expQ.push_back(E_RST);
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e) begin nFail++; $display("FAIL timeout_reset: got %b expected %b", obs, e); end
      @(negedge CLK);
      Reset_in = 1'b1;
      idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN);
      apply(idle);
      @(negedge CLK);
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e) begin nFail++; $display("FAIL timeout_recover: got %b expected %b", obs, e); end
      stallModel = (e[7]) ? stallModel : stallModel + 1;
   endtask

   task automatic test_async_reset();
      step_t s[$];
      step_t idle;
      logic [7:0] e;
      s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
      s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
      foreach (s[i]) begin
         apply(s[i]);
         @(negedge CLK);
         e = expQ.pop_front();
         nChecks++;
         if (obs !== e) begin nFail++; $display("FAIL async_pre step %0d: got %b expected %b", i, obs, e); end
         if (!e[7]) stallModel++;
      end
      // Reset lands between edges: strobes and counter must clear with no clock.
      #2;
      Reset_in = 1'b0;
      #1;
      stallModel = 0;
      expQ.push_back(E_RST);
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e) begin nFail++; $display("FAIL async_reset_outputs: got %b expected %b", obs, e); end
      nChecks++;
      if (stall_cnt !== 32'd0) begin nFail++; $display("FAIL async_reset_cnt: got %0d expected 0", stall_cnt); end
      mem_req = 1'b0;
      @(negedge CLK);
      Reset_in = 1'b1;
      idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN);
      apply(idle);
      @(negedge CLK);
      e = expQ.pop_front();
      nChecks++;
      if (obs !== e) begin nFail++; $display("FAIL async_recover: got %b expected %b", obs, e); end
      nChecks++;
      if (stall_cnt !== expCnt()) begin nFail++; $display("FAIL async_recover_cnt: got %0d expected %0d", stall_cnt, expCnt()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
